// File: rtl/s2b_counter.sv
// s2b_counter: counts ones in a unipolar stochastic bitstream over a fixed window and emits a binary value.
// Optional macro S2B_CONT_EN selects continuous back-to-back windows.
module s2b_counter #(
  parameter int DATAWD = 8,
  parameter int WINLOG = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iStart,
  input  logic              iClr,
  input  logic              iEn,
  input  logic              iBit,
  output logic [DATAWD-1:0] oB,
  output logic              oValid,
  output logic              oBusy
);

  localparam int SH = WINLOG - DATAWD;

  if (WINLOG < DATAWD) begin : g_bad_cfg
    $error("s2b_counter: WINLOG must be >= DATAWD");
  end

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

`ifdef S2B_CONT_EN
  localparam state_t END_ST = ACC;
`else
  localparam state_t END_ST = IDLE;
`endif

  state_t            state;
  state_t            state_n;
  logic [WINLOG:0]   ones;
  logic [WINLOG:0]   ones_n;
  logic [WINLOG-1:0] cnt;
  logic [WINLOG-1:0] cnt_n;
  logic [DATAWD-1:0] ob_n;
  logic              valid_n;
  logic              last;
  logic [WINLOG:0]   total;
  logic [WINLOG-1:0] sat;

  // Window ends on the final qualified bit; that bit is folded in here.
  assign last  = (state == ACC) && iEn && (&cnt);
  assign total = ones + (WINLOG+1)'(iBit);
  assign sat   = total[WINLOG] ? '1 : total[WINLOG-1:0];

  // Next-state, counter and result logic; abort wins over everything.
  always_comb begin
    state_n = state;
    ones_n  = ones;
    cnt_n   = cnt;
    ob_n    = oB;
    valid_n = 1'b0;
    if (iClr) begin
      state_n = IDLE;
      ones_n  = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iStart) begin
            state_n = ACC;
            ones_n  = '0;
            cnt_n   = '0;
          end
        end
        ACC: begin
          if (last) begin
            ob_n    = DATAWD'(sat >> SH);
            valid_n = 1'b1;
            state_n = END_ST;
            ones_n  = '0;
            cnt_n   = '0;
          end else if (iEn) begin
            cnt_n  = cnt + 1'b1;
            ones_n = total;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State, counters and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ones   <= '0;
      cnt    <= '0;
      oB     <= '0;
      oValid <= 1'b0;
    end else begin
      state  <= state_n;
      ones   <= ones_n;
      cnt    <= cnt_n;
      oB     <= ob_n;
      oValid <= valid_n;
    end
  end

  assign oBusy = (state == ACC);

endmodule

// File: tb/tb_s2b_counter.sv
// tb_s2b_counter: directed checks of s2b_counter for WINLOG=8 and WINLOG=10.
// Continuous-window checks run when S2B_CONT_EN is defined.
module tb_s2b_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_start = 0, a_clr = 0, a_en = 0, a_bit = 0;
  logic [7:0] a_b;
  logic       a_valid, a_busy;
  logic       b_start = 0, b_clr = 0, b_en = 0, b_bit = 0;
  logic [7:0] b_b;
  logic       b_valid, b_busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  s2b_counter #(.DATAWD(8), .WINLOG(8)) u_a (
    .clk(clk), .rst_n(rst_n), .iStart(a_start), .iClr(a_clr),
    .iEn(a_en), .iBit(a_bit), .oB(a_b), .oValid(a_valid), .oBusy(a_busy)
  );

  s2b_counter #(.DATAWD(8), .WINLOG(10)) u_b (
    .clk(clk), .rst_n(rst_n), .iStart(b_start), .iClr(b_clr),
    .iEn(b_en), .iBit(b_bit), .oB(b_b), .oValid(b_valid), .oBusy(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // iStart cycle also drives iEn=1,iBit=1 to show it is ignored.
  task automatic win8(input int nones, input bit alt, input int kick,
                      input int hold, input string tag);
    a_start = 1; a_en = 1; a_bit = 1;
    step();
    a_start = 0;
    chk({tag, "_busy_on"}, 32'(a_busy), 1);
    for (int i = 0; i < 256; i++) begin
      a_bit   = alt ? (i % 2 == 0) : (i < nones);
      a_start = (i == kick);
      step();
      if (i == 254) begin
        chk({tag, "_valid_early"}, 32'(a_valid), 0);
        chk({tag, "_hold"}, 32'(a_b), 32'(hold));
      end
    end
    a_start = 0; a_en = 0; a_bit = 0;
    chk({tag, "_valid"}, 32'(a_valid), 1);
    chk({tag, "_busy_off"}, 32'(a_busy), 0);
  endtask

  initial begin
    step();
    step();
    chk("rst_ob", 32'(a_b), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_ob10", 32'(b_b), 0);
    rst_n = 1;
    step();

`ifdef S2B_CONT_EN
    a_start = 1;
    step();
    a_start = 0;
    chk("cont_busy_on", 32'(a_busy), 1);
    for (int i = 0; i < 768; i++) begin
      int w;
      int k;
      int n;
      w = i / 256;
      k = i % 256;
      n = (w == 0) ? 64 : (w == 1) ? 192 : 256;
      a_en  = 1;
      a_bit = (k < n);
      step();
      chk("cont_busy", 32'(a_busy), 1);
      chk("cont_valid", 32'(a_valid), 32'(k == 255));
      if (k == 255)
        chk("cont_ob", 32'(a_b), (w == 0) ? 64 : (w == 1) ? 192 : 255);
    end
    a_en = 0; a_bit = 0;
    step();
    chk("cont_busy_idle_gap", 32'(a_busy), 1);
    chk("cont_valid_off", 32'(a_valid), 0);
    chk("cont_ob_hold", 32'(a_b), 255);
    a_clr = 1;
    step();
    a_clr = 0;
    chk("cont_clr_busy", 32'(a_busy), 0);
    chk("cont_clr_ob", 32'(a_b), 255);
`else
    win8(256, 0, -1, 0, "ones");
    chk("ones_ob", 32'(a_b), 255);
    step();
    chk("ones_valid_off", 32'(a_valid), 0);
    chk("ones_ob_hold", 32'(a_b), 255);

    win8(0, 0, -1, 255, "zeros");
    chk("zeros_ob", 32'(a_b), 0);

    win8(0, 1, -1, 0, "alt");
    chk("alt_ob", 32'(a_b), 128);

    a_start = 1;
    step();
    a_start = 0;
    for (int c = 0; c < 512; c++) begin
      a_en  = (c % 2 == 0);
      a_bit = ((c / 2) % 2 == 0);
      step();
      if (c >= 500)
        chk("gap_valid", 32'(a_valid), 32'(c == 510));
      if (c == 510)
        chk("gap_ob", 32'(a_b), 128);
    end
    a_en = 0; a_bit = 0;
    chk("gap_busy_off", 32'(a_busy), 0);

    a_start = 1;
    step();
    a_start = 0;
    a_en = 1; a_bit = 1;
    repeat (100) step();
    a_en = 0; a_clr = 1;
    step();
    a_clr = 0;
    chk("clr_busy", 32'(a_busy), 0);
    chk("clr_valid", 32'(a_valid), 0);
    chk("clr_ob", 32'(a_b), 128);

    win8(0, 0, -1, 128, "fresh");
    chk("fresh_ob", 32'(a_b), 0);

    win8(100, 0, 50, 0, "kick");
    chk("kick_ob", 32'(a_b), 100);

    a_start = 1;
    step();
    a_start = 0;
    a_en = 1; a_bit = 1;
    repeat (255) step();
    a_clr = 1;
    step();
    a_clr = 0; a_en = 0; a_bit = 0;
    chk("clrend_valid", 32'(a_valid), 0);
    chk("clrend_busy", 32'(a_busy), 0);
    chk("clrend_ob", 32'(a_b), 100);

    a_start = 1; a_clr = 1;
    step();
    a_start = 0; a_clr = 0;
    chk("clrstart_busy", 32'(a_busy), 0);

    b_start = 1;
    step();
    b_start = 0;
    b_en = 1;
    for (int i = 0; i < 1024; i++) begin
      b_bit = (i < 512);
      step();
      if (i == 1022)
        chk("w10_half_early", 32'(b_valid), 0);
    end
    b_en = 0;
    chk("w10_half_valid", 32'(b_valid), 1);
    chk("w10_half_ob", 32'(b_b), 128);

    b_start = 1;
    step();
    b_start = 0;
    b_en = 1; b_bit = 1;
    repeat (1024) step();
    b_en = 0; b_bit = 0;
    chk("w10_full_valid", 32'(b_valid), 1);
    chk("w10_full_ob", 32'(b_b), 255);
    chk("w10_full_busy", 32'(b_busy), 0);
`endif

    a_start = 1;
    step();
    a_start = 0;
    a_en = 1; a_bit = 1;
    repeat (50) step();
    rst_n = 0;
    #1;
    chk("arst_busy", 32'(a_busy), 0);
    chk("arst_ob", 32'(a_b), 0);
    chk("arst_valid", 32'(a_valid), 0);
    a_en = 0; a_bit = 0;
    step();
    rst_n = 1;
    step();
    chk("arst_after_busy", 32'(a_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/s2b_counter.md
Name: s2b_counter

Overview:
- Stochastic-to-binary converter that sits directly upstream of the binary multiplier.
- Counts the ones in a unipolar bitstream over a fixed window of 2^WINLOG qualified bits.
- Scales the count to DATAWD bits and presents it with a one-cycle valid strobe.
- Its oB output drives one binary multiplier operand; iA and iB each use one instance.

Parameters:
- DATAWD, 8, width of the binary result; matches the multiplier operand width.
- WINLOG, 8, log2 of the window length in qualified bits; WINLOG >= DATAWD is required (elaboration-time check).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- iStart  input  1  pulse that begins a window; honoured only in IDLE.
- iClr  input  1  synchronous abort; returns to IDLE.
- iEn  input  1  qualifies iBit this cycle.
- iBit  input  1  stochastic bitstream input.
- oB  output  DATAWD  converted binary value.
- oValid  output  1  one-cycle strobe; oB updated this cycle.
- oBusy  output  1  high while a window is in progress.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low; all other state changes on the rising edge of clk.
- Reset values: state=IDLE, ones counter=0, bit counter=0, oB=0, oValid=0, oBusy=0.
- Internal counters:
  - ones counter: WINLOG+1 bits.
  - bit counter: WINLOG bits.
- States: IDLE, ACC.
- IDLE:
  - iStart=1 (and iClr=0) -> ACC; both counters cleared.
  - iEn/iBit are ignored in IDLE, including in the iStart cycle.
- ACC:
  - Each cycle with iEn=1: bit counter +1; ones counter +iBit.
  - Cycles with iEn=0 change nothing, so gaps are allowed.
  - iStart is ignored.
- Window end: the edge at which iEn=1 and bit counter = 2^WINLOG-1.
  - total = ones + iBit, range 0..2^WINLOG.
  - sat = min(total, 2^WINLOG-1).
  - oB <= sat >> (WINLOG-DATAWD).
  - oValid <= 1 for exactly the following cycle.
  - State -> IDLE; counters cleared.
- Latency: oValid is asserted 1 cycle after the last qualified bit is sampled.
- oB holds its value until the next window end; it is never cleared except by reset.
- oBusy = (state==ACC), registered with the state.
- iClr:
  - In any state, next edge: state=IDLE, counters cleared, oValid=0, oB held.
  - iClr has priority over iStart and over window end in the same cycle.
- rst_n asserted mid-window: immediate return to reset values; no partial result is emitted.
- Bit counter wraps only at window end, never beyond.
- Saturation applies only to total=2^WINLOG (all ones), which yields the all-ones oB.

Optional Feature:
- Macro: S2B_CONT_EN.
- Defined (continuous mode):
  - At window end the state stays ACC; counters clear on the same edge.
  - The next qualified bit, on the very next cycle, is bit 0 of the new window: no bubble.
  - oBusy stays high.
  - iStart is ignored in ACC; the first window still requires iStart from IDLE.
  - iClr behaves as in the base behaviour.
- Not defined: one window per iStart, as described in Behaviour.

Test Plan:
- DATAWD=8, WINLOG=8; iStart, then 256 cycles of iEn=1, iBit=1 -> oValid pulse one cycle after the last bit, oB=255 (saturated), oBusy falls with it.
- Same setup, iBit=0 for all 256 bits -> oB=0; alternating 1,0 starting with 1 -> oB=128.
- 128 ones spread with iEn low every other cycle (512 cycles total, 256 qualified bits) -> oB=128; oValid exactly one cycle after the 256th qualified bit.
- WINLOG=10, DATAWD=8; 512 ones out of 1024 bits -> oB=128; 1024 ones -> oB=255.
- iClr after 100 bits, then a fresh iStart and 256 zero bits -> previous oB retained until the new oValid, then oB=0. Also: iStart pulsed mid-window -> no restart, window length unchanged.
- S2B_CONT_EN defined; iStart once, then 768 continuous bits with 64, 192, 256 ones per window -> oB = 64, 192, 255 on three oValid pulses spaced exactly 256 cycles apart; oBusy stays high throughout.
